// File: rtl/preg_free_list_pkg.sv
// Shared rename-stage constants, pointer type and slot-compaction helper.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package preg_free_list_pkg;

  localparam int FETCH_WIDTH  = 2;
  localparam int COMMIT_WIDTH = 2;
  localparam int NUM_PREG     = 64;
  localparam int NUM_CREG     = 32;
  localparam int PREG_W       = $clog2(NUM_PREG);
  localparam int FL_DEPTH     = NUM_PREG - NUM_CREG;
  localparam int IDX_W        = $clog2(FL_DEPTH);
  // One extra wrap bit so that full (count == FL_DEPTH) and empty are distinct.
  localparam int PTR_W        = IDX_W + 1;
  localparam int CNT_W        = PTR_W;

  // Widest slot mask any caller (free list, ROB allocator) hands to prefix_cnt.
  localparam int MASK_W       = 8;

  typedef logic [PTR_W-1:0]  fl_ptr_t;
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [MASK_W-1:0] mask_t;

  // Number of set bits in mask[k-1:0]; prefix_cnt(mask, width) is the full popcount.
  function automatic fl_ptr_t prefix_cnt(input mask_t mask, input int k);
    fl_ptr_t cnt;
    cnt = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (i < k && mask[i]) cnt = cnt + fl_ptr_t'(1);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/preg_free_list_fl_ring.sv
// Free-list storage: DEPTH x DAT_W flop array, RD_PORTS async reads, WR_PORTS writes.
// Latency: reads combinational; writes visible the cycle after the edge.
// Backpressure: none; callers guarantee write indices are distinct within a cycle.
// Ports: clk, resetn (async active-low), rd_idx_i/rd_dat_o per read port,
//        wr_en_i/wr_idx_i/wr_dat_i per write port. Reset loads entry i with INIT_BASE+i.
module fl_ring #(
  parameter int DEPTH     = 32,
  parameter int DAT_W     = 6,
  parameter int RD_PORTS  = 2,
  parameter int WR_PORTS  = 2,
  parameter int INIT_BASE = 32,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [RD_PORTS-1:0][IDX_W-1:0]     rd_idx_i,
  output logic [RD_PORTS-1:0][DAT_W-1:0]     rd_dat_o,
  input  logic [WR_PORTS-1:0]                wr_en_i,
  input  logic [WR_PORTS-1:0][IDX_W-1:0]     wr_idx_i,
  input  logic [WR_PORTS-1:0][DAT_W-1:0]     wr_dat_i
);

  logic [DAT_W-1:0] ring_q [DEPTH];
  logic [DAT_W-1:0] ring_d [DEPTH];

  always_comb begin
    ring_d = ring_q;
    for (int w = 0; w < WR_PORTS; w++) begin
      if (wr_en_i[w]) ring_d[wr_idx_i[w]] = wr_dat_i[w];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= DAT_W'(INIT_BASE + i);
    end else begin
      ring_q <= ring_d;
    end
  end

  always_comb begin
    for (int r = 0; r < RD_PORTS; r++) rd_dat_o[r] = ring_q[rd_idx_i[r]];
  end

endmodule

// File: rtl/preg_free_list.sv
// Physical register free list: grants up to FETCH_WIDTH pregs/cycle, reclaims commit's old pregs.
// Latency: grant ids and ready are combinational; pointers move at the next edge.
// Backpressure: alloc_ready_o low when fewer free entries than requested; no partial grant.
// Ports: clk, resetn (async active-low); alloc_valid_i/alloc_req_i -> alloc_ready_o/alloc_id_o;
//        commit_valid_i/commit_old_preg_i return pregs; flush_i rewinds speculative allocs;
//        free_count_o = tail - spec_head.
module preg_free_list
  import preg_free_list_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 alloc_valid_i,
  input  logic [FETCH_WIDTH-1:0]               alloc_req_i,
  output logic                                 alloc_ready_o,
  output logic [FETCH_WIDTH-1:0][PREG_W-1:0]   alloc_id_o,
  input  logic [COMMIT_WIDTH-1:0]              commit_valid_i,
  input  logic [COMMIT_WIDTH-1:0][PREG_W-1:0]  commit_old_preg_i,
  input  logic                                 flush_i,
  output logic [CNT_W-1:0]                     free_count_o
);

  if ((FL_DEPTH & (FL_DEPTH - 1)) != 0) begin : g_depth_not_pow2
    $error("FL_DEPTH must be a power of two");
  end

  // spec_head: next entry rename hands out; arch_head: oldest entry not yet
  // retired by commit; tail: next slot commit writes a released preg into.
  fl_ptr_t spec_head_q, spec_head_d;
  fl_ptr_t arch_head_q, arch_head_d;
  fl_ptr_t tail_q,      tail_d;

  fl_ptr_t free_count;
  fl_ptr_t alloc_cnt;
  fl_ptr_t commit_cnt;
  logic    alloc_ready;
  logic    fire;

  logic [FETCH_WIDTH-1:0][IDX_W-1:0]  rd_idx;
  logic [COMMIT_WIDTH-1:0][IDX_W-1:0] wr_idx;

  always_comb begin
    free_count  = tail_q - spec_head_q;
    alloc_cnt   = prefix_cnt(mask_t'(alloc_req_i), FETCH_WIDTH);
    commit_cnt  = prefix_cnt(mask_t'(commit_valid_i), COMMIT_WIDTH);
    // Uses the pre-commit count: frees landing this cycle are not bypassed.
    alloc_ready = (free_count >= alloc_cnt);
    fire        = alloc_valid_i & alloc_ready & ~flush_i;

    // Requesting slots are compacted onto consecutive ring entries.
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      rd_idx[k] = IDX_W'(spec_head_q + prefix_cnt(mask_t'(alloc_req_i), k));
    end
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      wr_idx[j] = IDX_W'(tail_q + prefix_cnt(mask_t'(commit_valid_i), j));
    end

    tail_d      = tail_q + commit_cnt;
    arch_head_d = arch_head_q + commit_cnt;
    // Flush rewinds to the committed point including this cycle's retirements.
    if (flush_i)   spec_head_d = arch_head_d;
    else if (fire) spec_head_d = spec_head_q + alloc_cnt;
    else           spec_head_d = spec_head_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q      <= fl_ptr_t'(FL_DEPTH);
    end else begin
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

  fl_ring #(
    .DEPTH     (FL_DEPTH),
    .DAT_W     (PREG_W),
    .RD_PORTS  (FETCH_WIDTH),
    .WR_PORTS  (COMMIT_WIDTH),
    .INIT_BASE (NUM_CREG)
  ) u_ring (
    .clk      (clk),
    .resetn   (resetn),
    .rd_idx_i (rd_idx),
    .rd_dat_o (alloc_id_o),
    .wr_en_i  (commit_valid_i),
    .wr_idx_i (wr_idx),
    .wr_dat_i (commit_old_preg_i)
  );

  assign alloc_ready_o = alloc_ready;
  assign free_count_o  = free_count;

  // Offsets measured from tail-FL_DEPTH so ring order becomes plain compare.
  fl_ptr_t ring_base, arch_off, spec_off, outstanding;
  always_comb begin
    ring_base   = tail_q - fl_ptr_t'(FL_DEPTH);
    arch_off    = arch_head_q - ring_base;
    spec_off    = spec_head_q - ring_base;
    outstanding = spec_head_q - arch_head_q;
  end

  always @(posedge clk) begin
    if (resetn) begin
      assert (free_count <= fl_ptr_t'(FL_DEPTH));
      assert (arch_off <= spec_off);
      assert (commit_cnt <= outstanding);
    end
  end

endmodule

// File: tb/tb_preg_free_list.sv
// Bench for preg_free_list: directed vectors plus a randomized phase against a queue model.
// Expectations are queued per cycle by stimulus; a negedge monitor pops and compares them.
// Ends with a live-set closure check over all physical register ids.
module tb_preg_free_list;
  import preg_free_list_pkg::*;

  localparam int K_FREE  = 0;
  localparam int K_READY = 1;
  localparam int K_ID    = 2;

  logic                                 clk = 1'b0;
  logic                                 resetn = 1'b0;
  logic                                 alloc_valid = 1'b0;
  logic [FETCH_WIDTH-1:0]               alloc_req = '0;
  logic                                 alloc_ready;
  logic [FETCH_WIDTH-1:0][PREG_W-1:0]   alloc_id;
  logic [COMMIT_WIDTH-1:0]              commit_valid = '0;
  logic [COMMIT_WIDTH-1:0][PREG_W-1:0]  commit_old = '0;
  logic                                 flush = 1'b0;
  logic [CNT_W-1:0]                     free_count;

  preg_free_list dut (
    .clk               (clk),
    .resetn            (resetn),
    .alloc_valid_i     (alloc_valid),
    .alloc_req_i       (alloc_req),
    .alloc_ready_o     (alloc_ready),
    .alloc_id_o        (alloc_id),
    .commit_valid_i    (commit_valid),
    .commit_old_preg_i (commit_old),
    .flush_i           (flush),
    .free_count_o      (free_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    kind;
    int    slot;
    int    val;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Model: fl_q holds ring contents from arch_head to tail (always FL_DEPTH long);
  // the first spec_n of them are speculatively allocated. arch_q holds pregs mapped
  // by committed state, oldest first.
  int fl_q[$];
  int arch_q[$];
  int spec_n;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic ex(input int kind, input int slot, input int val, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.slot = slot; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    fl_q = {};
    arch_q = {};
    for (int i = 0; i < FL_DEPTH; i++) fl_q.push_back(NUM_CREG + i);
    for (int i = 0; i < NUM_CREG; i++) arch_q.push_back(i);
    spec_n = 0;
  endtask

  // Applies one cycle of inputs #1 after the edge and advances the model.
  // With rnd set, expectations come from the model and old pregs from arch_q.
  task automatic drive(input logic v, input logic [1:0] req, input logic [1:0] cv,
                       input int o0, input int o1, input logic fl, input bit rnd);
    int  cnt, p, old;
    bit  rdy;
    @(posedge clk);
    #1;
    alloc_valid = v;
    alloc_req   = req;
    flush       = fl;
    cnt = int'(req[0]) + int'(req[1]);
    rdy = ((FL_DEPTH - spec_n) >= cnt);
    if (rnd) begin
      ex(K_FREE, 0, FL_DEPTH - spec_n, "rnd_free");
      ex(K_READY, 0, int'(rdy), "rnd_ready");
      if (v && rdy) begin
        p = 0;
        for (int k = 0; k < 2; k++) begin
          if (req[k]) begin
            ex(K_ID, k, fl_q[spec_n + p], "rnd_id");
            p++;
          end
        end
      end
    end
    commit_valid = cv;
    commit_old   = '0;
    for (int j = 0; j < 2; j++) begin
      if (cv[j]) begin
        old = rnd ? arch_q.pop_front() : ((j == 0) ? o0 : o1);
        commit_old[j] = PREG_W'(old);
        fl_q.push_back(old);
        arch_q.push_back(fl_q.pop_front());
        spec_n--;
      end
    end
    if (fl) spec_n = 0;
    else if (v && rdy) spec_n += cnt;
  endtask

  task automatic rnd_cycle();
    logic       v, fl;
    logic [1:0] req, cv;
    int         maxc, c;
    v    = ($urandom_range(0, 3) != 0);
    req  = 2'($urandom_range(0, 3));
    maxc = (spec_n < 2) ? spec_n : 2;
    c    = $urandom_range(0, maxc);
    if (c == 2)      cv = 2'b11;
    else if (c == 1) cv = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
    else             cv = 2'b00;
    fl   = ($urandom_range(0, 24) == 0);
    drive(v, req, cv, 0, 0, fl, 1'b1);
  endtask

  // After a flush, drain every free entry and confirm free + mapped covers all ids once.
  task automatic union_check();
    bit seen [NUM_PREG];
    int dups, id, total;
    dups = 0;
    for (int i = 0; i < NUM_PREG; i++) seen[i] = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < FL_DEPTH / 2; i++) begin
      drive(1'b1, 2'b11, 2'b00, 0, 0, 1'b0, 1'b1);
      #4;
      for (int k = 0; k < 2; k++) begin
        id = int'(alloc_id[k]);
        if (seen[id]) dups++;
        seen[id] = 1'b1;
      end
    end
    foreach (arch_q[i]) begin
      if (seen[arch_q[i]]) dups++;
      seen[arch_q[i]] = 1'b1;
    end
    total = 0;
    for (int i = 0; i < NUM_PREG; i++) total += int'(seen[i]);
    check("dup_live_preg", dups, 0);
    check("live_union", total, NUM_PREG);
  endtask

  // Monitor: compares everything queued for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.cyc < cyc) check({e.name, "_stale"}, e.cyc, cyc);
        else if (e.kind == K_FREE) check(e.name, int'(free_count), e.val);
        else if (e.kind == K_READY) check(e.name, int'(alloc_ready), e.val);
        else if (alloc_valid && alloc_ready) check(e.name, int'(alloc_id[e.slot]), e.val);
        else check({e.name, "_grant"}, int'(alloc_ready), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    // Reset state observed while resetn is still low.
    drive(1'b0, 2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
    ex(K_FREE, 0, 32, "reset_free");
    ex(K_READY, 0, 1, "reset_ready");
    resetn = 1'b1;

    drive(1'b1, 2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
    ex(K_ID, 0, 32, "first_id0");
    ex(K_ID, 1, 33, "first_id1");
    ex(K_FREE, 0, 32, "first_free");
    ex(K_READY, 0, 1, "first_ready");

    drive(1'b1, 2'b10, 2'b00, 0, 0, 1'b0, 1'b0);
    ex(K_FREE, 0, 30, "second_free");
    ex(K_READY, 0, 1, "second_ready");
    ex(K_ID, 1, 34, "compact_id1");

    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
      ex(K_ID, 0, 35 + 2 * i, "fill_id0");
      ex(K_ID, 1, 36 + 2 * i, "fill_id1");
    end
    drive(1'b1, 2'b01, 2'b00, 0, 0, 1'b0, 1'b0);
    ex(K_ID, 0, 63, "last_id0");

    // Empty: request stalls while commit returns preg 5 in the same cycle.
    drive(1'b1, 2'b01, 2'b01, 5, 0, 1'b0, 1'b0);
    ex(K_FREE, 0, 0, "empty_free");
    ex(K_READY, 0, 0, "empty_ready");
    drive(1'b1, 2'b01, 2'b00, 0, 0, 1'b0, 1'b0);
    ex(K_FREE, 0, 1, "refill_free");
    ex(K_READY, 0, 1, "refill_ready");
    ex(K_ID, 0, 5, "refill_id0");

    // Reset asserted with alloc and commit in flight.
    drive(1'b1, 2'b11, 2'b11, 7, 8, 1'b0, 1'b0);
    resetn = 1'b0;
    model_reset();
    ex(K_FREE, 0, 32, "midrst_free");
    ex(K_READY, 0, 1, "midrst_ready");
    ex(K_ID, 0, 32, "midrst_id0");
    ex(K_ID, 1, 33, "midrst_id1");
    drive(1'b0, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
    resetn = 1'b1;

    // Allocate 6, commit 2 (old 3,4), then flush.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
      ex(K_ID, 0, 32 + 2 * i, "six_id0");
      ex(K_ID, 1, 33 + 2 * i, "six_id1");
    end
    drive(1'b0, 2'b00, 2'b11, 3, 4, 1'b0, 1'b0);
    ex(K_FREE, 0, 26, "six_free");
    drive(1'b1, 2'b11, 2'b00, 0, 0, 1'b1, 1'b0);
    ex(K_FREE, 0, 28, "preflush_free");
    ex(K_ID, 0, 38, "flush_shown_id0");
    ex(K_ID, 1, 39, "flush_shown_id1");
    drive(1'b1, 2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
    ex(K_FREE, 0, 32, "postflush_free");
    ex(K_READY, 0, 1, "postflush_ready");
    ex(K_ID, 0, 34, "postflush_id0");
    ex(K_ID, 1, 35, "postflush_id1");

    // Flush, commit 2'b11 and alloc 2'b11 in one cycle: alloc dropped.
    drive(1'b1, 2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
    ex(K_FREE, 0, 30, "pre_combo_free");
    drive(1'b1, 2'b11, 2'b11, 10, 11, 1'b1, 1'b0);
    ex(K_FREE, 0, 28, "combo_free");
    ex(K_ID, 0, 38, "combo_id0");
    drive(1'b1, 2'b11, 2'b00, 0, 0, 1'b0, 1'b0);
    ex(K_FREE, 0, 32, "after_combo_free");
    ex(K_ID, 0, 36, "after_combo_id0");
    ex(K_ID, 1, 37, "after_combo_id1");

    // Fresh start for the randomized phase.
    drive(1'b0, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
    resetn = 1'b0;
    model_reset();
    drive(1'b0, 2'b00, 2'b00, 0, 0, 1'b0, 1'b1);
    resetn = 1'b1;
    for (int i = 0; i < 1000; i++) rnd_cycle();

    union_check();

    drive(1'b0, 2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #6;
    check("drain_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
